// File: rtl/seq_fsm_ctrl.sv
// Frame controller around the 4-state sequence machine: accepts one serial bit per
// handshake, counts bits and s3 entries, pulses done at frame end. Optional trace: SEQ_TRACE_EN.
module seq_fsm_ctrl #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] frame_len,
  input  logic          bit_in,
  input  logic          bit_valid,
  output logic          bit_ready,
  output logic          busy,
  output logic          done,
  output logic          hit,
  output logic [1:0]    fsm_state,
  output logic [CW-1:0] bit_cnt,
  output logic [CW-1:0] hit_cnt
`ifdef SEQ_TRACE_EN
  ,
  output logic [7:0]    state_trace
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} ctrl_e;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  ctrl_e         ctrl_q, ctrl_d;
  logic [1:0]    fsm_state_q, fsm_state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] hit_cnt_q, hit_cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic          hit_q, hit_d;
  logic [1:0]    seq_nxt;
`ifdef SEQ_TRACE_EN
  logic [7:0]    trace_q, trace_d;
`endif

  function automatic logic [1:0] seq_next(input logic [1:0] s, input logic b);
    logic [1:0] n;
    case (s)
      2'b00:   n = b ? 2'b10 : 2'b01;
      2'b01:   n = b ? 2'b10 : 2'b00;
      2'b10:   n = b ? 2'b11 : 2'b01;
      default: n = b ? 2'b10 : 2'b01;
    endcase
    return n;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q      <= IDLE;
      fsm_state_q <= 2'b00;
      bit_cnt_q   <= '0;
      hit_cnt_q   <= '0;
      len_q       <= '0;
      hit_q       <= 1'b0;
`ifdef SEQ_TRACE_EN
      trace_q     <= 8'h00;
`endif
    end else begin
      ctrl_q      <= ctrl_d;
      fsm_state_q <= fsm_state_d;
      bit_cnt_q   <= bit_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      len_q       <= len_d;
      hit_q       <= hit_d;
`ifdef SEQ_TRACE_EN
      trace_q     <= trace_d;
`endif
    end
  end

  // abort outranks an accept in RUN: the bit is dropped and the counters hold
  always_comb begin
    ctrl_d      = ctrl_q;
    fsm_state_d = fsm_state_q;
    bit_cnt_d   = bit_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    len_d       = len_q;
    hit_d       = 1'b0;
    seq_nxt     = seq_next(fsm_state_q, bit_in);
`ifdef SEQ_TRACE_EN
    trace_d     = trace_q;
`endif
    case (ctrl_q)
      IDLE: begin
        if (start) begin
          len_d       = frame_len;
          fsm_state_d = 2'b00;
          bit_cnt_d   = '0;
          hit_cnt_d   = '0;
`ifdef SEQ_TRACE_EN
          trace_d     = 8'h00;
`endif
          ctrl_d      = (frame_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          ctrl_d = IDLE;
        end else if (bit_valid) begin
          fsm_state_d = seq_nxt;
          bit_cnt_d   = bit_cnt_q + CNT_ONE;
`ifdef SEQ_TRACE_EN
          trace_d     = {trace_q[5:0], seq_nxt};
`endif
          if (seq_nxt == 2'b11) begin
            hit_d = 1'b1;
            if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + CNT_ONE;
          end
          if (bit_cnt_d == len_q) ctrl_d = DONE;
        end
      end
      DONE:    ctrl_d = IDLE;
      default: ctrl_d = IDLE;
    endcase
  end

  always_comb begin
    bit_ready = (ctrl_q == RUN);
    busy      = (ctrl_q == RUN);
    done      = (ctrl_q == DONE);
    hit       = hit_q;
    fsm_state = fsm_state_q;
    bit_cnt   = bit_cnt_q;
    hit_cnt   = hit_cnt_q;
`ifdef SEQ_TRACE_EN
    state_trace = trace_q;
`endif
  end

endmodule
